// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: W-bit ripple of fa cells, one partial product per cycle.
// Latency W+1 cycles from start to done; start while busy is dropped, no backpressure on the product.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  mcand;
  logic [W-1:0]  acc;
  logic [W-1:0]  mq;
  logic [CW-1:0] count;
  logic [W-1:0]  addend;
  logic [W-1:0]  sum;
  logic          cy;
  logic [2*W-1:0] shifted;

  assign addend = mq[0] ? mcand : '0;

  // Each stage owns its carry net so the chain is a set of distinct signals.
  for (genvar i = 0; i < W; i++) begin : g_rc
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_mid
      assign ci = g_rc[i-1].co;
    end
    fa u_fa (
      .a    (acc[i]),
      .b    (addend[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end
  assign cy = g_rc[W-1].co;

  // Carry-out lands in the product MSB; the consumed multiplier bit drops off the bottom.
  assign shifted = {cy, sum, mq[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      count <= '0;
      p     <= '0;
    end else begin
      case (state)
        RUN: begin
          {acc, mq} <= shifted;
          count     <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            p     <= shifted;
          end
        end
        default: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks of shift_add_mult (W=8): latency, product, back-to-back, ignored start, reset abort.
module tb_shift_add_mult;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [2*W-1:0] p;

  int n_asserts = 0;
  int n_fail    = 0;

  shift_add_mult #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, expect W busy cycles, then a done pulse carrying exp, then p held.
  task automatic run_mult(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [15:0] exp);
    start = 1'b1; a = ta; b = tb_v;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_nodone", {31'd0, done}, 32'd0);
      step();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_notbusy", {31'd0, busy}, 32'd0);
    chk("product", {16'd0, p}, {16'd0, exp});
    step();
    chk("done_drop", {31'd0, done}, 32'd0);
    chk("product_hold", {16'd0, p}, {16'd0, exp});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int gap;
    bit seen;

    rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_p", {16'd0, p}, 32'd0);
    rst = 1'b0; start = 1'b0;
    step();

    run_mult(8'd13, 8'd11, 16'd143);
    run_mult(8'd255, 8'd255, 16'd65025);
    run_mult(8'd0, 8'd200, 16'd0);
    run_mult(8'd200, 8'd1, 16'd200);

    // Back-to-back with start held high: 6*7 then 9*9, pulses W+1 apart.
    start = 1'b1; a = 8'd6; b = 8'd7;
    step();
    a = 8'd9; b = 8'd9;
    for (int i = 0; i < W; i++) step();
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_p1", {16'd0, p}, 32'd42);
    step();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_phold", {16'd0, p}, 32'd42);
    for (int i = 0; i < W; i++) step();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_p2", {16'd0, p}, 32'd81);
    start = 1'b0;
    step();
    chk("b2b_idle", {30'd0, busy, done}, 32'd0);

    // start pulsed during RUN cycle 4 of 5*5 must be ignored.
    start = 1'b1; a = 8'd5; b = 8'd5;
    step();
    start = 1'b0;
    for (int i = 1; i < 4; i++) step();
    start = 1'b1; a = 8'd3; b = 8'd3;
    step();
    start = 1'b0;
    for (int i = 5; i <= W; i++) step();
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_p", {16'd0, p}, 32'd25);
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("ign_single", {30'd0, busy, done}, 32'd0);
    end

    // Reset in RUN cycle 3 aborts without a done pulse.
    start = 1'b1; a = 8'd7; b = 8'd9;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_p", {16'd0, p}, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    run_mult(8'd2, 8'd2, 16'd4);

    // Random products with random idle gaps.
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      start = 1'b1; a = ra; b = rb;
      step();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      seen = 1'b0;
      for (int c = 0; c < W + 3 && !seen; c++) begin
        chk("rnd_excl", {31'd0, busy & done}, 32'd0);
        if (done) begin
          seen = 1'b1;
          chk("rnd_p", {16'd0, p}, {16'd0, 16'(ra) * 16'(rb)});
        end else begin
          step();
        end
      end
      if (!seen) chk("rnd_timeout", 32'd0, 32'd1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
